crc_attach: RTL

CRC_ATTACH -- requirements
Module: crc_attach

---
 rtl/crc_attach_if.sv | 24 ++
 rtl/crc_attach.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/crc_attach_if.sv
// Serial payload-in / payload+CRC-out bundle for crc_attach.
// The master side drives payload bits; the slave side (the CRC block) drives the output stream.
interface crc_attach_if;
  logic in_valid;
  logic in_data;
  logic in_start;
  logic in_block_size;
  logic in_ready;
  logic CRC_start;
  logic CRC_data;
  logic CRC_valid;
  logic block_size;
  logic done;

  modport master (
    output in_valid, in_data, in_start, in_block_size,
    input  in_ready, CRC_start, CRC_data, CRC_valid, block_size, done
  );

  modport slave (
    input  in_valid, in_data, in_start, in_block_size,
    output in_ready, CRC_start, CRC_data, CRC_valid, block_size, done
  );
endinterface

// File: rtl/crc_attach.sv
// Serial CRC24A attach: forwards a payload bitstream one cycle late, then appends the CRC MSB first.
//
// state   | meaning
// IDLE    | waiting for in_start with in_valid; other accepted bits are dropped
// PAYLOAD | folding payload bits into the CRC and forwarding them
// APPEND  | shifting out the CRC register, one bit per cycle
// DONE    | last CRC bit on the output; done pulses on the following cycle
module crc_attach #(
  parameter int                 LARGE_K = 6144,
  parameter int                 SMALL_K = 1056,
  parameter int                 CRC_LEN = 24,
  parameter logic [CRC_LEN-1:0] POLY    = 24'h864CFB
) (
  input logic         clk,
  input logic         reset,
  crc_attach_if.slave bus
);

  localparam int CNT_W = ($clog2(LARGE_K + 1) < 13) ? 13 : $clog2(LARGE_K + 1);
  localparam logic [CNT_W-1:0] LAST_LARGE = CNT_W'(LARGE_K - CRC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SMALL = CNT_W'(SMALL_K - CRC_LEN - 1);
  localparam logic [CNT_W-1:0] APPEND_TC  = CNT_W'(CRC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    APPEND  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_LEN-1:0] crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               start_q, start_d;
  logic               data_q, data_d;
  logic               valid_q, valid_d;
  logic               bs_q, bs_d;
  logic               done_q, done_d;

  logic               accept;
  logic [CNT_W-1:0]   payload_last;

  function automatic logic [CRC_LEN-1:0] crc_step(input logic [CRC_LEN-1:0] crc,
                                                  input logic d);
    logic fb;
    fb = d ^ crc[CRC_LEN-1];
    return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  assign accept       = bus.in_valid & ready_q;
  assign payload_last = bs_q ? LAST_LARGE : LAST_SMALL;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    bs_d    = bs_q;
    start_d = 1'b0;
    data_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && bus.in_start) begin
          bs_d    = bus.in_block_size;
          crc_d   = crc_step('0, bus.in_data);
          cnt_d   = CNT_W'(1);
          start_d = 1'b1;
          data_d  = bus.in_data;
          valid_d = 1'b1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          crc_d   = crc_step(crc_q, bus.in_data);
          data_d  = bus.in_data;
          valid_d = 1'b1;
          // counter is reused as the APPEND down-counter once the payload ends
          if (cnt_q == payload_last) begin
            cnt_d   = APPEND_TC;
            state_d = APPEND;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      APPEND: begin
        data_d  = crc_q[CRC_LEN-1];
        valid_d = 1'b1;
        crc_d   = {crc_q[CRC_LEN-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == PAYLOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      bs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      start_q <= start_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      bs_q    <= bs_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.CRC_start  = start_q;
  assign bus.CRC_data   = data_q;
  assign bus.CRC_valid  = valid_q;
  assign bus.block_size = bs_q;
  assign bus.done       = done_q;

endmodule
